// File: rtl/riscv_rf_wb_arbiter.sv
// Writeback arbiter: grants up to two register-file writes per cycle, round-robin,
// and registers the winners onto write ports A and B one cycle later.
module riscv_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [ADDR_WIDTH-1:0]       waddr_a_o,
    output logic [DATA_WIDTH-1:0]       wdata_a_o,
    output logic                        we_a_o,
    output logic [ADDR_WIDTH-1:0]       waddr_b_o,
    output logic [DATA_WIDTH-1:0]       wdata_b_o,
    output logic                        we_b_o,
    output logic                        busy_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]      ready;
    logic                  use0, use1;
    logic [ADDR_WIDTH-1:0] s0_addr, s1_addr, cur_addr;
    logic [DATA_WIDTH-1:0] s0_data, s1_data;
    int                    scan_idx;
    int                    next_ptr;

    logic                  we_a_q, we_b_q;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;

    // Scan sources from rr_ptr with wraparound; x0 writes are swallowed without a slot,
    // and a second slot never repeats the first slot's destination.
    always_comb begin
        ready    = '0;
        use0     = 1'b0;
        use1     = 1'b0;
        s0_addr  = '0;
        s1_addr  = '0;
        s0_data  = '0;
        s1_data  = '0;
        cur_addr = '0;
        scan_idx = 0;
        next_ptr = int'(rr_ptr_q);
        if (rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
                cur_addr = req_addr_i[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
                if (req_valid_i[scan_idx]) begin
                    if (cur_addr == '0) begin
                        ready[scan_idx] = 1'b1;
                        next_ptr        = scan_idx + 1;
                    end else if (use0 && (cur_addr == s0_addr)) begin
                        ready[scan_idx] = 1'b0;
                    end else if (!use0) begin
                        ready[scan_idx] = 1'b1;
                        use0            = 1'b1;
                        s0_addr         = cur_addr;
                        s0_data         = req_data_i[scan_idx*DATA_WIDTH +: DATA_WIDTH];
                        next_ptr        = scan_idx + 1;
                    end else if (!use1) begin
                        ready[scan_idx] = 1'b1;
                        use1            = 1'b1;
                        s1_addr         = cur_addr;
                        s1_data         = req_data_i[scan_idx*DATA_WIDTH +: DATA_WIDTH];
                        next_ptr        = scan_idx + 1;
                    end
                end
            end
        end
        if (next_ptr >= N_REQ) next_ptr = next_ptr - N_REQ;
        rr_ptr_d = PTR_W'(next_ptr);
    end

    always_comb begin
        waddr_a_d = use0 ? s0_addr : waddr_a_q;
        wdata_a_d = use0 ? s0_data : wdata_a_q;
        waddr_b_d = use1 ? s1_addr : waddr_b_q;
        wdata_b_d = use1 ? s1_data : wdata_b_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            we_a_q    <= use0;
            we_b_q    <= use1;
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
        end
    end

    assign req_ready_o = ready;
    assign busy_o      = |(req_valid_i & ~ready);
    assign we_a_o      = we_a_q;
    assign waddr_a_o   = waddr_a_q;
    assign wdata_a_o   = wdata_a_q;
    assign we_b_o      = we_b_q;
    assign waddr_b_o   = waddr_b_q;
    assign wdata_b_o   = wdata_b_q;

endmodule
